mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the CPU data-memory port, sitting in the MEM stage between the pipeline and the word-wide data memory.
- Accepts one load/store per request and checks alignment and range, raising AdEL/AdES without touching memory.
- Issues word-aligned read/write transactions over a req/ack handshake. Sub-word stores become read-modify-write sequences.
- Returns sign/zero-extended load data and holds the pipeline (busy) until the access completes.

Parameters:
- ADDR_HI, 32'h0000_2fff, highest legal byte address; anything above faults.
- OP_W, 3, width of the op code.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- req_valid  in  1  pipeline request; held high until resp_valid.
- req_op  in  3  LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/half used for SB/SH.
- req_pc  in  32  PC of the instruction, forwarded for write logging.
- busy  out  1  stall pipeline.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- adel  out  1  load address fault, valid with resp_valid.
- ades  out  1  store address fault, valid with resp_valid.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, bits [1:0] always 00.
- mem_wdata  out  32  write data.
- mem_pc  out  32  registered req_pc.
- mem_ack  in  1  memory accepted/completed the transaction; mem_rdata valid this cycle for reads.
- mem_rdata  in  32  read data.

Behaviour:
- Reset (sync, active-high): state=IDLE. busy, resp_valid, adel, ades, mem_req, mem_we = 0. resp_rdata, mem_addr, mem_wdata, mem_pc = 0.
- Reset mid-operation: abort at that edge and drop mem_req. A write not yet acked is not performed. No resp_valid is issued.
- States: IDLE, RD, RMW_RD, RMW_WR, WR, DONE. All outputs are registered.
- IDLE with req_valid: latch op/addr/wdata/pc; busy=1 from the next cycle.
  - Fault check: LW/SW require addr[1:0]==0; LH/LHU/SH require addr[0]==0; all ops require addr <= ADDR_HI (unsigned).
  - Fault -> DONE with adel (loads) or ades (stores) =1. No mem_req is ever raised.
  - Otherwise: loads -> RD; SW -> WR; SH/SB -> RMW_RD.
- RD / RMW_RD: mem_req=1, mem_we=0, mem_addr={addr[31:2],2'b00}. Stay in state while mem_ack=0. On mem_ack, capture mem_rdata. RD -> DONE; RMW_RD -> RMW_WR.
- RMW_WR: mem_req=1, mem_we=1. mem_wdata = captured word with the target lane replaced, little-endian.
  - SB: lane k=addr[1:0] occupies bits [8k+7:8k].
  - SH: addr[1]=0 -> bits [15:0]; addr[1]=1 -> bits [31:16].
  - Holds while mem_ack=0. On mem_ack -> DONE.
- WR: mem_req=1, mem_we=1, mem_wdata=req_wdata; on mem_ack -> DONE.
- mem_req, mem_we, mem_addr and mem_wdata stay stable while waiting for ack. mem_req drops the cycle after ack; back-to-back RMW has exactly one mem_req=0 cycle between read and write.
- DONE (exactly 1 cycle): resp_valid=1, busy=1. Then -> IDLE with busy=0.
  - resp_rdata: LW = word; LH/LB sign-extend the selected lane; LHU/LBU zero-extend.
- req_valid is sampled only in IDLE. Minimum latency from acceptance to resp_valid:
  - fault: 1 cycle.
  - LW/SW/loads with ack in the first request cycle: 2 cycles.
  - SB/SH: 4 cycles.
- mem_ack while mem_req=0 is ignored.

Decomposition:
- Shared package holds:
  - op encodings LW..SB;
  - state encoding;
  - ADDR_HI default;
  - function lane_extract(word, addr[1:0], op) returning the extended 32-bit value;
  - function lane_merge(word, data, addr[1:0], op).
- One sub-module is natural: mau_align_check (combinational: op, addr -> adel, ades).

Test Plan:
- LW addr 0x0000_0010, memory word 0x8899AABB, ack on first request cycle -> mem_addr=0x10, mem_we=0; resp_valid 2 cycles after accept; resp_rdata=0x8899AABB; adel=0.
- LB 0x11 and LBU 0x11 on word 0x8899AABB -> resp_rdata 0xFFFFFFAA and 0x000000AA respectively.
- SB addr 0x13, wdata 0x12345677, word 0x8899AABB, ack delayed 3 cycles on each phase -> read then write. mem_wdata=0x7799AABB, mem_pc=req_pc; mem_req held through the waits; one mem_req=0 cycle between read and write.
- LW 0x0000_0012 -> adel=1, no mem_req; SH 0x0000_3000 -> ades=1, no mem_req; resp_rdata=0 in both cases.
- SH addr 0x2FFE, wdata 0xBEEF, word 0x11223344 -> mem_wdata=0xBEEF3344; ades=0.
- Reset asserted in RMW_WR while mem_ack=0 -> next cycle mem_req=0, busy=0, state IDLE; no resp_valid; memory contents unchanged.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and lane helpers for the MEM-stage data-memory initiator.
// Lane numbering is little-endian: byte k of a word occupies bits [8k+7:8k].
package mem_access_unit_pkg;

  localparam int          OP_W_DEF    = 3;
  localparam logic [31:0] ADDR_HI_DEF = 32'h0000_2fff;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_RMW_WR = 3'd3,
    ST_WR     = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  function automatic logic is_store(input op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Selects the addressed lane of a loaded word and extends it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input op_e         op);
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    w_half = lane[1] ? word[31:16] : word[15:0];
    w_byte = word[8*lane +: 8];
    case (op)
      OP_LW:   return word;
      OP_LH:   return {{16{w_half[15]}}, w_half};
      OP_LHU:  return {16'h0000, w_half};
      OP_LB:   return {{24{w_byte[7]}}, w_byte};
      OP_LBU:  return {24'h00_0000, w_byte};
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Replaces the addressed lane of a word with store data (SB/SH only).
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [15:0] data,
                                             input logic [1:0]  lane,
                                             input op_e         op);
    logic [31:0] w_res;
    w_res = word;
    case (op)
      OP_SB: w_res[8*lane +: 8] = data[7:0];
      OP_SH: begin
        if (lane[1]) w_res[31:16] = data;
        else         w_res[15:0]  = data;
      end
      default: w_res = word;
    endcase
    return w_res;
  endfunction

endpackage

// File: rtl/mem_access_unit_align_check.sv
// Combinational alignment and range check for one load/store request.
// Faulting requests never reach the memory port.
module mau_align_check
  import mem_access_unit_pkg::*;
#(
  parameter logic [31:0] ADDR_HI = ADDR_HI_DEF
) (
  input  op_e         i_op,
  input  logic [31:0] i_addr,
  output logic        o_adel,
  output logic        o_ades
);

  logic w_misaligned;
  logic w_out_of_range;

  always_comb begin
    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    w_misaligned = 1'b0;
    case (i_op)
      OP_LW, OP_SW:         w_misaligned = |i_addr[1:0];
      OP_LH, OP_LHU, OP_SH: w_misaligned = i_addr[0];
      default:              w_misaligned = 1'b0;
    endcase
  end

  assign w_out_of_range = (i_addr > ADDR_HI);

  assign o_adel = (w_misaligned | w_out_of_range) & ~is_store(i_op);
  assign o_ades = (w_misaligned | w_out_of_range) &  is_store(i_op);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a word-wide data memory: checks, issues req/ack
// transactions (sub-word stores as read-modify-write) and returns load data.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter logic [31:0] ADDR_HI = ADDR_HI_DEF,
  parameter int          OP_W    = OP_W_DEF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            req_valid,
  input  logic [OP_W-1:0] req_op,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic [31:0]     req_pc,
  output logic            busy,
  output logic            resp_valid,
  output logic [31:0]     resp_rdata,
  output logic            adel,
  output logic            ades,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  output logic [31:0]     mem_pc,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata
);

  state_e      r_state,      w_nxt_state;
  op_e         r_op,         w_nxt_op;
  logic [1:0]  r_lane,       w_nxt_lane;
  logic [15:0] r_wdata,      w_nxt_wdata;
  logic        r_busy,       w_nxt_busy;
  logic        r_resp_valid, w_nxt_resp_valid;
  logic [31:0] r_resp_rdata, w_nxt_resp_rdata;
  logic        r_adel,       w_nxt_adel;
  logic        r_ades,       w_nxt_ades;
  logic        r_mem_req,    w_nxt_mem_req;
  logic        r_mem_we,     w_nxt_mem_we;
  logic [31:0] r_mem_addr,   w_nxt_mem_addr;
  logic [31:0] r_mem_wdata,  w_nxt_mem_wdata;
  logic [31:0] r_mem_pc,     w_nxt_mem_pc;

  op_e  w_op;
  logic w_adel;
  logic w_ades;

  assign w_op = op_e'(req_op);

  mau_align_check #(
    .ADDR_HI (ADDR_HI)
  ) u_align_check (
    .i_op   (w_op),
    .i_addr (req_addr),
    .o_adel (w_adel),
    .o_ades (w_ades)
  );

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_op         = r_op;
    w_nxt_lane       = r_lane;
    w_nxt_wdata      = r_wdata;
    w_nxt_busy       = r_busy;
    w_nxt_resp_valid = 1'b0;
    w_nxt_resp_rdata = r_resp_rdata;
    w_nxt_adel       = r_adel;
    w_nxt_ades       = r_ades;
    w_nxt_mem_req    = r_mem_req;
    w_nxt_mem_we     = r_mem_we;
    w_nxt_mem_addr   = r_mem_addr;
    w_nxt_mem_wdata  = r_mem_wdata;
    w_nxt_mem_pc     = r_mem_pc;

    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_nxt_op     = w_op;
          w_nxt_lane   = req_addr[1:0];
          w_nxt_wdata  = req_wdata[15:0];
          w_nxt_mem_pc = req_pc;
          w_nxt_busy   = 1'b1;
          if (w_adel || w_ades) begin
            w_nxt_state      = ST_DONE;
            w_nxt_resp_valid = 1'b1;
            w_nxt_resp_rdata = 32'h0000_0000;
            w_nxt_adel       = w_adel;
            w_nxt_ades       = w_ades;
          end else begin
            w_nxt_mem_req  = 1'b1;
            w_nxt_mem_addr = {req_addr[31:2], 2'b00};
            case (w_op)
              OP_SW: begin
                w_nxt_state     = ST_WR;
                w_nxt_mem_we    = 1'b1;
                w_nxt_mem_wdata = req_wdata;
              end
              OP_SH, OP_SB: begin
                w_nxt_state  = ST_RMW_RD;
                w_nxt_mem_we = 1'b0;
              end
              default: begin
                w_nxt_state  = ST_RD;
                w_nxt_mem_we = 1'b0;
              end
            endcase
          end
        end
      end

      ST_RD: begin
        if (mem_ack) begin
          w_nxt_state      = ST_DONE;
          w_nxt_mem_req    = 1'b0;
          w_nxt_resp_valid = 1'b1;
          w_nxt_resp_rdata = lane_extract(mem_rdata, r_lane, r_op);
        end
      end

      // The merged word is built at the read ack; the write is raised one cycle later.
      ST_RMW_RD: begin
        if (mem_ack) begin
          w_nxt_state     = ST_RMW_WR;
          w_nxt_mem_req   = 1'b0;
          w_nxt_mem_wdata = lane_merge(mem_rdata, r_wdata, r_lane, r_op);
        end
      end

      ST_RMW_WR: begin
        if (!r_mem_req) begin
          w_nxt_mem_req = 1'b1;
          w_nxt_mem_we  = 1'b1;
        end else if (mem_ack) begin
          w_nxt_state      = ST_DONE;
          w_nxt_mem_req    = 1'b0;
          w_nxt_mem_we     = 1'b0;
          w_nxt_resp_valid = 1'b1;
          w_nxt_resp_rdata = 32'h0000_0000;
        end
      end

      ST_WR: begin
        if (mem_ack) begin
          w_nxt_state      = ST_DONE;
          w_nxt_mem_req    = 1'b0;
          w_nxt_mem_we     = 1'b0;
          w_nxt_resp_valid = 1'b1;
          w_nxt_resp_rdata = 32'h0000_0000;
        end
      end

      ST_DONE: begin
        w_nxt_state = ST_IDLE;
        w_nxt_busy  = 1'b0;
        w_nxt_adel  = 1'b0;
        w_nxt_ades  = 1'b0;
      end

      default: begin
        w_nxt_state   = ST_IDLE;
        w_nxt_busy    = 1'b0;
        w_nxt_mem_req = 1'b0;
        w_nxt_mem_we  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_LW;
      r_lane       <= 2'b00;
      r_wdata      <= 16'h0000;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0000_0000;
      r_adel       <= 1'b0;
      r_ades       <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'h0000_0000;
      r_mem_wdata  <= 32'h0000_0000;
      r_mem_pc     <= 32'h0000_0000;
    end else begin
      r_state      <= w_nxt_state;
      r_op         <= w_nxt_op;
      r_lane       <= w_nxt_lane;
      r_wdata      <= w_nxt_wdata;
      r_busy       <= w_nxt_busy;
      r_resp_valid <= w_nxt_resp_valid;
      r_resp_rdata <= w_nxt_resp_rdata;
      r_adel       <= w_nxt_adel;
      r_ades       <= w_nxt_ades;
      r_mem_req    <= w_nxt_mem_req;
      r_mem_we     <= w_nxt_mem_we;
      r_mem_addr   <= w_nxt_mem_addr;
      r_mem_wdata  <= w_nxt_mem_wdata;
      r_mem_pc     <= w_nxt_mem_pc;
    end
  end

  assign busy       = r_busy;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign adel       = r_adel;
  assign ades       = r_ades;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_pc     = r_mem_pc;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table plus a reset-abort sequence,
// against a word memory model that answers with a programmable ack delay.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        busy, resp_valid, adel, ades;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_pc, mem_rdata;

  always #5 Clk = ~Clk;

  mem_access_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .adel       (adel),
    .ades       (ades),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_pc     (mem_pc),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Memory model: a write lands only when its ack has been taken by the DUT.
  logic [31:0] mem_model [0:4095];
  int          dly_rd = 0;
  int          dly_wr = 0;
  int          ack_cnt = 0;
  int          wr_count = 0;
  logic        ack_we;
  logic [31:0] ack_addr, ack_wdata, ack_pc, last_wr_pc;

  initial begin : responder
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge Clk);
      if (mem_ack) begin
        if (ack_we) begin
          mem_model[ack_addr[13:2]] = ack_wdata;
          wr_count++;
          last_wr_pc = ack_pc;
        end
        mem_ack = 1'b0;
        ack_cnt = 0;
      end else if (mem_req) begin
        if (ack_cnt == (mem_we ? dly_wr : dly_rd)) begin
          mem_ack   = 1'b1;
          ack_we    = mem_we;
          ack_addr  = mem_addr;
          ack_wdata = mem_wdata;
          ack_pc    = mem_pc;
          mem_rdata = mem_model[mem_addr[13:2]];
        end else begin
          ack_cnt++;
        end
      end else begin
        ack_cnt = 0;
      end
    end
  end

  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    int          dly;
    logic [31:0] init_word;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_adel;
    logic        exp_ades;
    logic [31:0] exp_word;
    int          exp_phases;
  } vec_t;

  localparam int N_VEC = 22;
  vec_t vecs [N_VEC];

  task automatic run_vec(input int idx, input vec_t v);
    int          lat = 0;
    int          phases = 0, gaps = 0, zero_run = 0;
    int          stab_err = 0, addr_err = 0, busy_err = 0;
    int          wc0;
    bit          seen = 0, done = 0;
    logic        prev_req = 1'b0, p_we = 1'b0, first_we = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0, got_rdata = '0;
    logic        got_adel = 1'b0, got_ades = 1'b0;
    logic [31:0] exp_addr;
    bit          exp_write;
    string       tag;

    tag       = $sformatf("v%0d", idx);
    exp_addr  = {v.addr[31:2], 2'b00};
    exp_write = (v.op == OP_SW || v.op == OP_SH || v.op == OP_SB) && !v.exp_ades;
    mem_model[v.addr[13:2]] = v.init_word;
    dly_rd = v.dly;
    dly_wr = v.dly;
    wc0 = wr_count;

    req_valid = 1'b1;
    req_op    = v.op;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_pc    = v.pc;

    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge Clk);
      if (!busy) busy_err++;
      if (mem_req) begin
        if (!prev_req) begin
          phases++;
          if (!seen) first_we = mem_we;
          else       gaps += zero_run;
          seen    = 1;
          p_addr  = mem_addr;
          p_we    = mem_we;
          p_wdata = mem_wdata;
          if (mem_addr !== exp_addr) addr_err++;
        end else if (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata) begin
          stab_err++;
        end
        zero_run = 0;
      end else begin
        zero_run++;
      end
      prev_req = mem_req;
      if (resp_valid) begin
        done      = 1;
        lat       = c;
        got_rdata = resp_rdata;
        got_adel  = adel;
        got_ades  = ades;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;

    check({tag, " latency"},   lat,       v.exp_lat);
    check({tag, " rdata"},     got_rdata, v.exp_rdata);
    check({tag, " adel"},      {31'b0, got_adel}, {31'b0, v.exp_adel});
    check({tag, " ades"},      {31'b0, got_ades}, {31'b0, v.exp_ades});
    check({tag, " phases"},    phases,    v.exp_phases);
    check({tag, " gap"},       gaps,      (v.exp_phases == 2) ? 1 : 0);
    check({tag, " stable"},    stab_err,  0);
    check({tag, " word addr"}, addr_err,  0);
    check({tag, " busy"},      busy_err,  0);
    if (phases > 0)
      check({tag, " first we"}, {31'b0, first_we}, {31'b0, (v.op == OP_SW)});

    @(negedge Clk);
    check({tag, " busy after"}, {31'b0, busy}, 32'h0);
    check({tag, " resp drop"},  {31'b0, resp_valid}, 32'h0);
    check({tag, " mem word"},   mem_model[v.addr[13:2]], v.exp_word);
    check({tag, " writes"},     wr_count - wc0, exp_write ? 1 : 0);
    if (exp_write) check({tag, " mem_pc"}, last_wr_pc, v.pc);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit seen_wr;

    vecs[0]  = '{OP_LW,  32'h0000_0010, 32'h0,         32'h0000_0400, 0, 32'h8899_AABB, 2,  32'h8899_AABB, 0, 0, 32'h8899_AABB, 1};
    vecs[1]  = '{OP_LB,  32'h0000_0011, 32'h0,         32'h0000_0404, 0, 32'h8899_AABB, 2,  32'hFFFF_FFAA, 0, 0, 32'h8899_AABB, 1};
    vecs[2]  = '{OP_LBU, 32'h0000_0011, 32'h0,         32'h0000_0408, 0, 32'h8899_AABB, 2,  32'h0000_00AA, 0, 0, 32'h8899_AABB, 1};
    vecs[3]  = '{OP_LH,  32'h0000_0012, 32'h0,         32'h0000_040C, 1, 32'h8899_AABB, 3,  32'hFFFF_8899, 0, 0, 32'h8899_AABB, 1};
    vecs[4]  = '{OP_LHU, 32'h0000_0012, 32'h0,         32'h0000_0410, 0, 32'h8899_AABB, 2,  32'h0000_8899, 0, 0, 32'h8899_AABB, 1};
    vecs[5]  = '{OP_LB,  32'h0000_0013, 32'h0,         32'h0000_0414, 0, 32'h8899_AABB, 2,  32'hFFFF_FF88, 0, 0, 32'h8899_AABB, 1};
    vecs[6]  = '{OP_LB,  32'h0000_0010, 32'h0,         32'h0000_0418, 0, 32'h0000_007F, 2,  32'h0000_007F, 0, 0, 32'h0000_007F, 1};
    vecs[7]  = '{OP_LH,  32'h0000_0014, 32'h0,         32'h0000_041C, 0, 32'h0000_8001, 2,  32'hFFFF_8001, 0, 0, 32'h0000_8001, 1};
    vecs[8]  = '{OP_SB,  32'h0000_0013, 32'h1234_5677, 32'h0000_0420, 3, 32'h8899_AABB, 10, 32'h0,         0, 0, 32'h7799_AABB, 2};
    vecs[9]  = '{OP_SB,  32'h0000_0010, 32'h0000_0055, 32'h0000_0424, 0, 32'h8899_AABB, 4,  32'h0,         0, 0, 32'h8899_AA55, 2};
    vecs[10] = '{OP_SH,  32'h0000_2FFE, 32'h0000_BEEF, 32'h0000_0428, 0, 32'h1122_3344, 4,  32'h0,         0, 0, 32'hBEEF_3344, 2};
    vecs[11] = '{OP_SH,  32'h0000_0014, 32'h0000_CAFE, 32'h0000_042C, 1, 32'h1122_3344, 6,  32'h0,         0, 0, 32'h1122_CAFE, 2};
    vecs[12] = '{OP_SW,  32'h0000_0020, 32'hDEAD_BEEF, 32'h0000_0430, 1, 32'h0000_0000, 3,  32'h0,         0, 0, 32'hDEAD_BEEF, 1};
    vecs[13] = '{OP_LW,  32'h0000_0012, 32'h0,         32'h0000_0434, 0, 32'h8899_AABB, 1,  32'h0,         1, 0, 32'h8899_AABB, 0};
    vecs[14] = '{OP_SH,  32'h0000_3000, 32'h0000_1234, 32'h0000_0438, 0, 32'hCAFE_F00D, 1,  32'h0,         0, 1, 32'hCAFE_F00D, 0};
    vecs[15] = '{OP_LHU, 32'h0000_3001, 32'h0,         32'h0000_043C, 0, 32'h0000_0000, 1,  32'h0,         1, 0, 32'h0000_0000, 0};
    vecs[16] = '{OP_SB,  32'h0000_3000, 32'h0000_00FF, 32'h0000_0440, 0, 32'hCAFE_F00D, 1,  32'h0,         0, 1, 32'hCAFE_F00D, 0};
    vecs[17] = '{OP_SH,  32'h0000_0001, 32'h0000_FFFF, 32'h0000_0444, 0, 32'h0000_0055, 1,  32'h0,         0, 1, 32'h0000_0055, 0};
    vecs[18] = '{OP_SW,  32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0448, 0, 32'h0000_0055, 1,  32'h0,         0, 1, 32'h0000_0055, 0};
    vecs[19] = '{OP_LW,  32'h0000_2FFC, 32'h0,         32'h0000_044C, 0, 32'h0BAD_CAFE, 2,  32'h0BAD_CAFE, 0, 0, 32'h0BAD_CAFE, 1};
    vecs[20] = '{OP_LBU, 32'h0000_2FFF, 32'h0,         32'h0000_0450, 0, 32'hA100_0000, 2,  32'h0000_00A1, 0, 0, 32'hA100_0000, 1};
    vecs[21] = '{OP_LW,  32'hFFFF_FFFC, 32'h0,         32'h0000_0454, 0, 32'h0000_0000, 1,  32'h0,         1, 0, 32'h0000_0000, 0};

    Reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_pc    = 32'h0;
    repeat (3) @(negedge Clk);
    check("reset busy",       {31'b0, busy},       32'h0);
    check("reset resp_valid", {31'b0, resp_valid}, 32'h0);
    check("reset mem_req",    {31'b0, mem_req},    32'h0);
    check("reset mem_we",     {31'b0, mem_we},     32'h0);
    check("reset flags",      {30'b0, adel, ades}, 32'h0);
    check("reset resp_rdata", resp_rdata,          32'h0);
    check("reset mem_addr",   mem_addr,            32'h0);
    check("reset mem_wdata",  mem_wdata,           32'h0);
    check("reset mem_pc",     mem_pc,              32'h0);
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < N_VEC; i++) run_vec(i, vecs[i]);

    // Reset while the RMW write is waiting for an ack that never comes.
    mem_model[16] = 32'h1111_1111;
    dly_rd    = 0;
    dly_wr    = 1000;
    req_valid = 1'b1;
    req_op    = OP_SB;
    req_addr  = 32'h0000_0041;
    req_wdata = 32'h0000_00AB;
    req_pc    = 32'h0000_0800;
    seen_wr   = 0;
    for (int c = 0; c < 20 && !seen_wr; c++) begin
      @(negedge Clk);
      if (mem_req && mem_we) seen_wr = 1;
    end
    check("abort reached write", {31'b0, seen_wr}, 32'h1);
    check("abort wdata", mem_wdata, 32'h1111_AB11);
    repeat (2) @(negedge Clk);
    Reset     = 1'b1;
    req_valid = 1'b0;
    @(negedge Clk);
    check("abort mem_req", {31'b0, mem_req}, 32'h0);
    check("abort busy",    {31'b0, busy},    32'h0);
    check("abort resp",    {31'b0, resp_valid}, 32'h0);
    Reset = 1'b0;
    begin
      int resp_seen = 0;
      int req_seen  = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge Clk);
        if (resp_valid) resp_seen++;
        if (mem_req)    req_seen++;
      end
      check("abort no resp",  resp_seen, 0);
      check("abort idle",     req_seen,  0);
    end
    check("abort mem word", mem_model[16], 32'h1111_1111);
    dly_wr = 0;

    run_vec(100, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
